mx_block_quantizer: RTL and testbench

//  Encoder counterpart of the MX MAC datapath: converts a stream of accumulator results
//  {sign, 8b biased exp, M_out_width mant, hidden 1} into one MX block: an 8b shared exponent

---
 rtl/mx_quant_pkg.sv | 27 ++
 rtl/mx_elem_quant.sv | 46 ++++
 rtl/mx_block_quantizer.sv | 153 +++++++++++++++
 tb/tb_mx_block_quantizer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mx_quant_pkg.sv
// Shared types and helpers for the MX block quantizer.
// Precision encodings map to the element bit-width P.
package mx_quant_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_e;

    localparam logic [1:0] PREC_8 = 2'd0;
    localparam logic [1:0] PREC_4 = 2'd1;
    localparam logic [1:0] PREC_2 = 2'd2;

    localparam int EXP_BIAS = 127;

    function automatic logic [3:0] prec_bits(input logic [1:0] mode);
        logic [3:0] p;
        p = 4'd8;
        unique case (mode)
            PREC_4:  p = 4'd4;
            PREC_2:  p = 4'd2;
            default: p = 4'd8;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/mx_elem_quant.sv
// Combinational quantiser for one element: align to the shared exponent,
// round half away from zero, saturate to P bits and apply the sign.
module mx_elem_quant #(
    parameter int M = 23
) (
    input  logic [M-1:0] mant_i,
    input  logic [7:0]   exp_i,
    input  logic         sign_i,
    input  logic [7:0]   max_exp_i,
    input  logic [3:0]   p_i,
    output logic [7:0]   elem_o,
    output logic         sat_o
);

    localparam int EW = M + 8;

    logic [7:0]    d;
    logic [9:0]    sh;
    logic [EW-1:0] ext;
    logic [EW-1:0] r;
    logic [EW-1:0] q;
    logic [7:0]    qmax;
    logic [7:0]    qc;
    logic          zero;

    always_comb begin
        d    = max_exp_i - exp_i;
        sh   = 10'(M) + 10'(d) + 10'd8 - 10'(p_i);
        // hidden 1, fraction, 2^6 headroom for P-2, one extra bit for rounding
        ext  = {1'b1, mant_i, 7'b0};
        r    = ext >> sh;
        q    = (r >> 1) + EW'(r[0]);
        qmax = 8'((9'd1 << (p_i - 4'd1)) - 9'd1);
        zero = (exp_i == 8'd0) || (10'(d) > 10'(M) + 10'(p_i));
        sat_o = !zero && (q > EW'(qmax));
        if (zero) begin
            qc = 8'd0;
        end else if (sat_o) begin
            qc = qmax;
        end else begin
            qc = q[7:0];
        end
        elem_o = sign_i ? -qc : qc;
    end

endmodule

// File: rtl/mx_block_quantizer.sv
// Collects BLOCK_SIZE accumulator results and streams them out as one MX block.
// Define MX_SAT_CNT_EN to add the per-block saturation counter output sat_cnt.
module mx_block_quantizer
    import mx_quant_pkg::*;
#(
    parameter int M_out_width = 23,
    parameter int BLOCK_SIZE  = 32
) (
    input  logic                   clk_i,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [M_out_width-1:0] in_mant,
    input  logic [7:0]             in_exp,
    input  logic                   in_sign,
    input  logic [1:0]             prec_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_shared_exp,
    output logic [7:0]             out_elem,
    output logic                   out_last
`ifdef MX_SAT_CNT_EN
    ,
    output logic [$clog2(BLOCK_SIZE):0] sat_cnt
`endif
);

    localparam int IW = $clog2(BLOCK_SIZE);
    localparam logic [IW-1:0] LAST = IW'(BLOCK_SIZE - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    max_q, max_d;
    logic [3:0]    p_q, p_d;

    logic                   buf_sign_q [BLOCK_SIZE];
    logic [7:0]             buf_exp_q  [BLOCK_SIZE];
    logic [M_out_width-1:0] buf_mant_q [BLOCK_SIZE];

    logic       in_fire;
    logic       out_fire;
    logic [7:0] q_elem;
    logic       unused_sat;

    assign in_fire  = in_valid && (state_q == COLLECT);
    assign out_fire = out_ready && (state_q == EMIT);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        max_d   = max_q;
        p_d     = p_q;
        unique case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    idx_d = idx_q + 1'b1;
                    if (in_exp > max_q) max_d = in_exp;
                    if (idx_q == '0) p_d = prec_bits(prec_mode);
                    if (idx_q == LAST) state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        state_d = COLLECT;
                        max_d   = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            max_q   <= '0;
            p_q     <= 4'd8;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            max_q   <= max_d;
            p_q     <= p_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_fire) begin
            buf_sign_q[idx_q] <= in_sign;
            buf_exp_q[idx_q]  <= in_exp;
            buf_mant_q[idx_q] <= in_mant;
        end
    end

    mx_elem_quant #(.M(M_out_width)) u_quant (
        .mant_i    (buf_mant_q[idx_q]),
        .exp_i     (buf_exp_q[idx_q]),
        .sign_i    (buf_sign_q[idx_q]),
        .max_exp_i (max_q),
        .p_i       (p_q),
        .elem_o    (q_elem),
        .sat_o     (unused_sat)
    );

    assign in_ready       = (state_q == COLLECT);
    assign out_valid      = (state_q == EMIT);
    assign out_last       = out_valid && (idx_q == LAST);
    assign out_shared_exp = out_valid ? max_q : 8'd0;
    assign out_elem       = out_valid ? q_elem : 8'd0;

`ifdef MX_SAT_CNT_EN
    // Only elements at the running max exponent can saturate, so the count
    // restarts whenever a larger exponent arrives.
    logic [IW:0] sat_q, sat_d;
    logic [3:0]  p_cur;
    logic        s_sat;
    logic [7:0]  unused_s_elem;

    assign p_cur = (idx_q == '0) ? prec_bits(prec_mode) : p_q;

    mx_elem_quant #(.M(M_out_width)) u_sat_probe (
        .mant_i    (in_mant),
        .exp_i     (in_exp),
        .sign_i    (1'b0),
        .max_exp_i (in_exp),
        .p_i       (p_cur),
        .elem_o    (unused_s_elem),
        .sat_o     (s_sat)
    );

    always_comb begin
        sat_d = sat_q;
        if (in_fire) begin
            if (in_exp > max_q) begin
                sat_d = {{IW{1'b0}}, s_sat};
            end else if (in_exp == max_q) begin
                sat_d = sat_q + {{IW{1'b0}}, s_sat};
            end
        end
        if (out_fire && (idx_q == LAST)) sat_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst) sat_q <= '0;
        else     sat_q <= sat_d;
    end

    assign sat_cnt = sat_q;
`endif

endmodule

// File: tb/tb_mx_block_quantizer.sv
// Directed self-checking bench for mx_block_quantizer.
// Expected element values are derived by hand from the quantisation rule.
module tb_mx_block_quantizer;

    localparam int M  = 23;
    localparam int BS = 32;

    logic         clk_i = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [M-1:0] in_mant = '0;
    logic [7:0]   in_exp = '0;
    logic         in_sign = 1'b0;
    logic [1:0]   prec_mode = 2'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   out_shared_exp;
    logic [7:0]   out_elem;
    logic         out_last;
`ifdef MX_SAT_CNT_EN
    logic [$clog2(BS):0] sat_cnt;
`endif

    mx_block_quantizer #(.M_out_width(M), .BLOCK_SIZE(BS)) dut (
        .clk_i          (clk_i),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_mant        (in_mant),
        .in_exp         (in_exp),
        .in_sign        (in_sign),
        .prec_mode      (prec_mode),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_shared_exp (out_shared_exp),
        .out_elem       (out_elem),
        .out_last       (out_last)
`ifdef MX_SAT_CNT_EN
        ,
        .sat_cnt        (sat_cnt)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int want_sat = 0;

    logic [7:0]   v_exp  [BS];
    logic [M-1:0] v_mant [BS];
    logic         v_sign [BS];
    logic [7:0]   v_elem [BS];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [7:0] e, input logic [M-1:0] m,
                        input logic [7:0] q);
        for (int i = 0; i < BS; i++) begin
            v_exp[i]  = e;
            v_mant[i] = m;
            v_sign[i] = 1'b0;
            v_elem[i] = q;
        end
    endtask

    task automatic push(input logic [1:0] prec, input logic [1:0] prec_late);
        for (int i = 0; i < BS; i++) begin
            @(negedge clk_i);
            if (i == 0) check("push_ready", in_ready, 1);
            in_valid  = 1'b1;
            in_exp    = v_exp[i];
            in_mant   = v_mant[i];
            in_sign   = v_sign[i];
            prec_mode = (i == 0) ? prec : prec_late;
        end
        @(negedge clk_i);
        in_valid = 1'b0;
        in_exp   = '0;
        in_mant  = '0;
        in_sign  = 1'b0;
    endtask

    task automatic drain(input string tag, input logic [7:0] sh,
                         input int sat, input int stall_at, input int abort_at);
        want_sat  = sat;
        out_ready = 1'b1;
        for (int k = 0; k < BS; k++) begin
            if (k == abort_at) begin
                rst = 1'b1;
                @(negedge clk_i);
                rst = 1'b0;
                check({tag, "_rst_valid"}, out_valid, 0);
                check({tag, "_rst_ready"}, in_ready, 1);
                check({tag, "_rst_shexp"}, out_shared_exp, 0);
                check({tag, "_rst_elem"}, out_elem, 0);
                return;
            end
            check($sformatf("%s_valid%0d", tag, k), out_valid, 1);
            check($sformatf("%s_elem%0d", tag, k), out_elem, v_elem[k]);
            check($sformatf("%s_last%0d", tag, k), out_last, (k == BS - 1));
            check($sformatf("%s_shexp%0d", tag, k), out_shared_exp, sh);
            check($sformatf("%s_noin%0d", tag, k), in_ready, 0);
`ifdef MX_SAT_CNT_EN
            if (k == 0) check({tag, "_satcnt"}, sat_cnt, want_sat);
`endif
            if (k == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk_i);
                    check($sformatf("%s_hold_elem%0d", tag, s), out_elem, v_elem[k]);
                    check($sformatf("%s_hold_shexp%0d", tag, s), out_shared_exp, sh);
                    check($sformatf("%s_hold_ready%0d", tag, s), in_ready, 0);
                    check($sformatf("%s_hold_valid%0d", tag, s), out_valid, 1);
                end
                out_ready = 1'b1;
            end
            @(negedge clk_i);
        end
        check({tag, "_done_valid"}, out_valid, 0);
        check({tag, "_done_ready"}, in_ready, 1);
`ifdef MX_SAT_CNT_EN
        check({tag, "_done_sat"}, sat_cnt, 0);
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        rst = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_last", out_last, 0);
        check("rst_shexp", out_shared_exp, 0);
        check("rst_elem", out_elem, 0);
`ifdef MX_SAT_CNT_EN
        check("rst_sat", sat_cnt, 0);
`endif

        // 1.0 at P=8 -> 64
        fill(8'd127, '0, 8'h40);
        push(2'd0, 2'd0);
        drain("t1", 8'd127, 0, -1, -1);

        // 1.111.. rounds to 128 -> clipped to 127
        fill(8'd127, '0, 8'h40);
        v_mant[5] = '1;
        v_elem[5] = 8'h7F;
        push(2'd0, 2'd0);
        drain("t2", 8'd127, 1, -1, -1);

        // P=4: 4, 2, 1, 0.5->1, 0.25->0, -4; mid-block prec change ignored
        fill(8'd0, 23'h12345, 8'h00);
        v_exp[0] = 8'd127; v_elem[0] = 8'd4;
        v_exp[1] = 8'd126; v_elem[1] = 8'd2;
        v_exp[2] = 8'd125; v_elem[2] = 8'd1;
        v_exp[3] = 8'd124; v_elem[3] = 8'd1;
        v_exp[4] = 8'd123; v_elem[4] = 8'd0;
        v_exp[5] = 8'd127; v_sign[5] = 1'b1; v_elem[5] = 8'hFC;
        for (int i = 0; i < 6; i++) v_mant[i] = '0;
        push(2'd1, 2'd0);
        drain("t3", 8'd127, 0, -1, -1);

        fill(8'd0, 23'h7FFFFF, 8'h00);
        for (int i = 0; i < BS; i++) v_sign[i] = i[0];
        push(2'd0, 2'd0);
        drain("t4", 8'd0, 0, -1, -1);

        // P=2: d=0 -> 1, d=1 (0.5) -> 1, d=2 (0.25) -> 0; odd elements negative
        for (int i = 0; i < BS; i++) begin
            v_exp[i]  = 8'd127 - 8'(i % 3);
            v_mant[i] = '0;
            v_sign[i] = i[0];
            if (i % 3 == 2)  v_elem[i] = 8'h00;
            else if (i[0])   v_elem[i] = 8'hFF;
            else             v_elem[i] = 8'h01;
        end
        v_mant[0] = 23'h400000;
        push(2'd2, 2'd3);
        drain("t5", 8'd127, 1, 10, -1);

        fill(8'd127, '0, 8'h40);
        push(2'd0, 2'd0);
        drain("t6a", 8'd127, 0, -1, 7);

        fill(8'd0, '0, 8'h00);
        v_exp[3] = 8'd130; v_elem[3] = 8'h40;
        v_exp[9] = 8'd129; v_sign[9] = 1'b1; v_elem[9] = 8'hE0;
        v_exp[20] = 8'd128; v_mant[20] = 23'h400000; v_elem[20] = 8'h18;
        push(2'd0, 2'd0);
        drain("t6b", 8'd130, 0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
